// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Index and counter widths are derived from the instantiating module's parameters.
package fifo_arb_pkg;

  localparam int DEF_DSIZE     = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter is one bit wider than needed to hold MAX_BURST-1.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotate-priority encoder: first set request bit at or above
// rr_ptr, wrapping modulo NREQ.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            any_req,
  output logic [IW-1:0]   winner
);

  logic found;
  int   idx;

  // NOTE: every signal driven here gets a default before the loop, so no latch is inferred.
  always_comb begin
    any_req = |req;
    winner  = rr_ptr;
    found   = 1'b0;
    idx     = 0;
    for (int ofs = 0; ofs < NREQ; ofs++) begin
      idx = int'(rr_ptr) + ofs;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port between NREQ
// requesters; lives entirely in the wclk domain and never pushes while wfull.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DSIZE     = DEF_DSIZE,
  parameter  int NREQ      = DEF_NREQ,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int IW        = idx_width(NREQ),
  localparam int CW        = cnt_width(MAX_BURST)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IW-1:0]         grant_id,
  output logic                  busy
);

  arb_state_e        state;
  logic [IW-1:0]     rr_ptr;
  logic [CW-1:0]     beat_cnt;

  logic              any_req;
  logic [IW-1:0]     winner;
  logic              cur_valid;
  logic              cur_last;
  logic [DSIZE-1:0]  cur_data;
  logic              acc;
  logic              burst_end;
  logic [IW-1:0]     next_ptr;

  rr_priority_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .winner  (winner)
  );

  // Select the granted requester's lane.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IW'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_data  = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // A beat is pushed in the same cycle it is offered; wfull simply stalls.
  assign acc       = (state == BURST) && cur_valid && !wfull;
  assign burst_end = acc && (cur_last || (beat_cnt == CW'(MAX_BURST - 1)));
  assign next_ptr  = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  assign winc  = acc;
  assign wdata = cur_data;
  assign busy  = (state == BURST);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (acc && (grant_id == IW'(i))) req_ready[i] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            state    <= IDLE;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end else if (acc) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
